// File: rtl/alu_exec_ctrl.sv
// Multicycle execute controller: fetches an instruction on Run, sequences
// operand latch (A), ALU evaluation (G) and writeback into an 8-entry register file.
module alu_exec_ctrl #(
  parameter int N   = 16,
  parameter int SHW = 4
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         Run,
  input  logic [N-1:0] DIN,
  input  logic [2:0]   RdSel,
  output logic [N-1:0] RdData,
  output logic         Busy,
  output logic         Done
);

  typedef enum logic [1:0] {S_IDLE, S_T1, S_T2, S_T3} state_t;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_SLT = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SRL = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_MV  = 4'b0110;
  localparam logic [3:0] OP_MVI = 4'b0111;

  state_t         state_q, state_d;
  // Only op/rX/rY are kept; the low six instruction bits carry no meaning.
  logic [9:0]     ir_q, ir_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   g_q, g_d;
  logic           done_q, done_d;
  logic [N-1:0]   rf_q [8];
  logic [N-1:0]   rf_d [8];

  logic           we;
  logic [2:0]     waddr;
  logic [N-1:0]   wdata;
  logic [3:0]     op;
  logic [2:0]     rx, ry;
  logic [N-1:0]   y;
  logic [N-1:0]   alu_res;

  assign op = ir_q[9:6];
  assign rx = ir_q[5:3];
  assign ry = ir_q[2:0];
  assign y  = rf_q[ry];

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = a_q + y;
      OP_SUB:  alu_res = a_q - y;
      OP_SLT:  alu_res = (a_q < y) ? N'(1) : '0;
      OP_SLL:  alu_res = a_q << y[SHW-1:0];
      OP_SRL:  alu_res = a_q >> y[SHW-1:0];
      OP_AND:  alu_res = a_q & y;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    a_d     = a_q;
    g_d     = g_q;
    done_d  = 1'b0;
    we      = 1'b0;
    waddr   = rx;
    wdata   = g_q;
    case (state_q)
      S_IDLE: begin
        if (Run) begin
          ir_d    = DIN[N-1 -: 10];
          state_d = S_T1;
        end
      end
      S_T1: begin
        if (op == OP_MV) begin
          we      = 1'b1;
          wdata   = y;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (op == OP_MVI) begin
          we      = 1'b1;
          wdata   = DIN;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (op <= OP_AND) begin
          a_d     = rf_q[rx];
          state_d = S_T2;
        end else begin
          // Illegal opcode: complete without touching the register file.
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_T2: begin
        g_d     = alu_res;
        state_d = S_T3;
      end
      S_T3: begin
        we      = 1'b1;
        wdata   = g_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      a_q     <= '0;
      g_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      g_q     <= g_d;
      done_q  <= done_d;
    end
  end

  // Flop-based register file: needs async clear and a combinational debug read.
  for (genvar gi = 0; gi < 8; gi++) begin : g_rf
    assign rf_d[gi] = (we && (waddr == 3'(gi))) ? wdata : rf_q[gi];

    always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) rf_q[gi] <= '0;
      else       rf_q[gi] <= rf_d[gi];
    end
  end

  assign RdData = rf_q[RdSel];
  assign Busy   = (state_q != S_IDLE);
  assign Done   = done_q;

endmodule
